// File: rtl/int_gen_pkg.sv
// +----------------------------------------------------------------------------+
// | int_gen_pkg: register offsets, CTRL bit indices, state encoding, helpers    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package int_gen_pkg;

  localparam logic [31:0] c_BASE_ADDR = 32'h0000_7F20;

  localparam logic [4:0] c_IG_ACK    = 5'h00;
  localparam logic [4:0] c_IG_CTRL   = 5'h04;
  localparam logic [4:0] c_IG_PERIOD = 5'h08;
  localparam logic [4:0] c_IG_COUNT  = 5'h0C;
  localparam logic [4:0] c_IG_TRIGPC = 5'h10;

  localparam int c_CTRL_EN   = 0;
  localparam int c_CTRL_MODE = 1;
  localparam int c_CTRL_PCM  = 2;

  typedef enum logic [1:0] {
    IG_IDLE  = 2'd0,
    IG_COUNT = 2'd1,
    IG_PEND  = 2'd2
  } ig_state_t;

  // Replace only the byte lanes enabled by the store.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_v;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_gen_regs.sv
// +----------------------------------------------------------------------------+
// | int_gen_regs: address decode, byte-lane merge, PERIOD/TRIGPC storage and    |
// | read mux. TRIGPC exists only when INTGEN_PCMATCH_EN is defined.             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module int_gen_regs
  import int_gen_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = c_BASE_ADDR,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_byteen,
  input  logic [2:0]       i_ctrl,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_ack_we,
  output logic             o_ctrl_we,
  output logic [2:0]       o_ctrl_wdata,
  output logic [CNT_W-1:0] o_period,
  output logic [31:0]      o_trigpc,
  output logic [31:0]      o_rdata
);

  localparam logic [31:0] c_ACK_ADDR    = BASE_ADDR + 32'(c_IG_ACK);
  localparam logic [31:0] c_CTRL_ADDR   = BASE_ADDR + 32'(c_IG_CTRL);
  localparam logic [31:0] c_PERIOD_ADDR = BASE_ADDR + 32'(c_IG_PERIOD);
  localparam logic [31:0] c_COUNT_ADDR  = BASE_ADDR + 32'(c_IG_COUNT);

  logic             w_store;
  logic             w_hit_ack;
  logic             w_hit_ctrl;
  logic             w_hit_period;
  logic             w_hit_count;
  logic             w_unused_addr;
  logic [CNT_W-1:0] r_period;

  assign w_store      = |i_byteen;
  assign w_hit_ack    = (i_addr[31:2] == c_ACK_ADDR[31:2]);
  assign w_hit_ctrl   = (i_addr[31:2] == c_CTRL_ADDR[31:2]);
  assign w_hit_period = (i_addr[31:2] == c_PERIOD_ADDR[31:2]);
  assign w_hit_count  = (i_addr[31:2] == c_COUNT_ADDR[31:2]);
  assign w_unused_addr = ^i_addr[1:0];

  // CTRL lives in lane 0 only; a store that skips lane 0 leaves it alone.
  assign o_ack_we     = w_store & w_hit_ack;
  assign o_ctrl_we    = w_hit_ctrl & i_byteen[0];
  assign o_ctrl_wdata = i_wdata[2:0];
  assign o_period     = r_period;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
    end else if (w_store && w_hit_period) begin
      r_period <= CNT_W'(byte_merge(32'(r_period), i_wdata, i_byteen));
    end
  end

`ifdef INTGEN_PCMATCH_EN
  localparam logic [31:0] c_TRIGPC_ADDR = BASE_ADDR + 32'(c_IG_TRIGPC);

  logic        w_hit_trigpc;
  logic [31:0] r_trigpc;

  assign w_hit_trigpc = (i_addr[31:2] == c_TRIGPC_ADDR[31:2]);
  assign o_trigpc     = r_trigpc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trigpc <= '0;
    end else if (w_store && w_hit_trigpc) begin
      r_trigpc <= byte_merge(r_trigpc, i_wdata, i_byteen);
    end
  end
`else
  assign o_trigpc = '0;
`endif

  always_comb begin
    o_rdata = '0;
    if (w_hit_ctrl) begin
      o_rdata = 32'(i_ctrl);
    end else if (w_hit_period) begin
      o_rdata = 32'(r_period);
    end else if (w_hit_count) begin
      o_rdata = 32'(i_count);
    end
`ifdef INTGEN_PCMATCH_EN
    else if (w_hit_trigpc) begin
      o_rdata = r_trigpc;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/int_gen.sv
// +----------------------------------------------------------------------------+
// | int_gen: memory-mapped external interrupt generator (one-shot / periodic),  |
// | optional PC-match trigger under INTGEN_PCMATCH_EN.                          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module int_gen
  import int_gen_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = c_BASE_ADDR,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] rdata,
  output logic        interrupt
);

  ig_state_t        r_state;
  logic [2:0]       r_ctrl;
  logic [CNT_W-1:0] r_count;
  logic             r_irq;

  logic             w_ack_we;
  logic             w_ctrl_we;
  logic [2:0]       w_ctrl_wdata;
  logic [2:0]       w_ctrl_mask;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_reload;
  logic [31:0]      w_trigpc;
  logic             w_pc_hit;

  int_gen_regs #(
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) u_regs (
    .clk          (clk),
    .rst          (reset),
    .i_addr       (m_data_addr),
    .i_wdata      (m_data_wdata),
    .i_byteen     (m_data_byteen),
    .i_ctrl       (r_ctrl),
    .i_count      (r_count),
    .o_ack_we     (w_ack_we),
    .o_ctrl_we    (w_ctrl_we),
    .o_ctrl_wdata (w_ctrl_wdata),
    .o_period     (w_period),
    .o_trigpc     (w_trigpc),
    .o_rdata      (rdata)
  );

  // A zero period still needs one edge to elapse before the request.
  assign w_reload = (w_period == '0) ? CNT_W'(1) : w_period;

`ifdef INTGEN_PCMATCH_EN
  assign w_ctrl_mask = 3'b111;
  assign w_pc_hit    = r_ctrl[c_CTRL_EN] & r_ctrl[c_CTRL_PCM] &
                       (r_state != IG_PEND) & (m_inst_addr == w_trigpc);
`else
  logic w_unused_pc;
  assign w_ctrl_mask = 3'b011;
  assign w_pc_hit    = 1'b0;
  assign w_unused_pc = ^{m_inst_addr, w_trigpc};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IG_IDLE;
      r_ctrl  <= '0;
      r_count <= '0;
      r_irq   <= 1'b0;
    end else if (w_ctrl_we) begin
      // Any CTRL write drops a pending request and restarts or stops the count.
      r_ctrl <= w_ctrl_wdata & w_ctrl_mask;
      r_irq  <= 1'b0;
      if (w_ctrl_wdata[c_CTRL_EN]) begin
        r_count <= w_reload;
        r_state <= IG_COUNT;
      end else begin
        r_count <= '0;
        r_state <= IG_IDLE;
      end
    end else if (w_pc_hit) begin
      r_count <= '0;
      r_state <= IG_PEND;
      r_irq   <= 1'b1;
    end else begin
      case (r_state)
        IG_COUNT: begin
          if (r_count == CNT_W'(1)) begin
            r_count <= '0;
            r_state <= IG_PEND;
            r_irq   <= 1'b1;
          end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        IG_PEND: begin
          if (w_ack_we) begin
            r_irq <= 1'b0;
            if (r_ctrl[c_CTRL_MODE] && r_ctrl[c_CTRL_EN]) begin
              r_count <= w_reload;
              r_state <= IG_COUNT;
            end else begin
              r_ctrl[c_CTRL_EN] <= 1'b0;
              r_state           <= IG_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign interrupt = r_irq;

endmodule

`default_nettype wire
